// File: rtl/mac_sequencer.sv
// Dot-product sequencer: walks romA/romB addresses for one job, aligns the
// accumulator enables to ROM data latency and reports completion.
module mac_sequencer #(
  parameter int NUM_BEATS = 64,
  parameter int ROM_LAT   = 1,
  parameter int TREE_LAT  = 1
) (
  input  logic        i_clock,
  input  logic        i_reset_l,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [11:0] i_a_base,
  input  logic [11:0] i_a_stride,
  input  logic [5:0]  i_b_base,
  output logic [11:0] o_romA_addr,
  output logic [5:0]  o_romB_addr,
  output logic        o_acc_en,
  output logic        o_acc_clear,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_result_valid,
  output logic [15:0] o_clock_cycle_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [11:0] LAST_BEAT  = 12'(NUM_BEATS - 1);
  localparam logic [3:0]  DRAIN_LAST = 4'(ROM_LAT + TREE_LAT - 1);

  state_t r_state;
  state_t w_next;

  logic [11:0]        r_beatIdx;
  logic [3:0]         r_drainCnt;
  logic [11:0]        r_aStride;
  logic [11:0]        r_romAAddr;
  logic [5:0]         r_romBAddr;
  logic [ROM_LAT-1:0] r_issuePipe;
  logic [ROM_LAT-1:0] r_firstPipe;
  logic               r_busy;
  logic               r_done;
  logic               r_resultValid;
  logic [15:0]        r_cycleCount;

  logic               w_idleLike;
  logic               w_busyState;
  logic               w_accept;
  logic               w_abort;
  logic               w_lastBeat;
  logic               w_drainEnd;
  logic               w_issueNow;
  logic               w_firstNow;
  logic [ROM_LAT:0]   w_issueExt;
  logic [ROM_LAT:0]   w_firstExt;

  // Abort takes priority over start in every state.
  assign w_idleLike  = (r_state == IDLE) || (r_state == DONE);
  assign w_busyState = (r_state == ISSUE) || (r_state == DRAIN);
  assign w_accept    = w_idleLike && i_start && !i_abort;
  assign w_abort     = w_busyState && i_abort;
  assign w_lastBeat  = (r_beatIdx == LAST_BEAT);
  assign w_drainEnd  = (r_drainCnt == DRAIN_LAST);
  assign w_issueNow  = (r_state == ISSUE) && !i_abort;
  assign w_firstNow  = w_issueNow && (r_beatIdx == 12'd0);
  assign w_issueExt  = {r_issuePipe, w_issueNow};
  assign w_firstExt  = {r_firstPipe, w_firstNow};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) w_next = ISSUE;
      end
      ISSUE: begin
        if (i_abort)         w_next = IDLE;
        else if (w_lastBeat) w_next = DRAIN;
      end
      DRAIN: begin
        if (i_abort)         w_next = IDLE;
        else if (w_drainEnd) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_state       <= IDLE;
      r_beatIdx     <= '0;
      r_drainCnt    <= '0;
      r_aStride     <= '0;
      r_romAAddr    <= '0;
      r_romBAddr    <= '0;
      r_issuePipe   <= '0;
      r_firstPipe   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_resultValid <= 1'b0;
      r_cycleCount  <= '0;
    end else begin
      r_state       <= w_next;
      r_busy        <= (w_next == ISSUE) || (w_next == DRAIN);
      r_done        <= (w_next == DONE);
      r_resultValid <= (w_next == DONE) && (r_state != DONE);

      // Latency pipes carry issue-valid and first-beat markers to ROM data time.
      if (w_abort) begin
        r_issuePipe <= '0;
        r_firstPipe <= '0;
      end else begin
        r_issuePipe <= w_issueExt[ROM_LAT-1:0];
        r_firstPipe <= w_firstExt[ROM_LAT-1:0];
      end

      if (w_accept) begin
        r_beatIdx    <= '0;
        r_drainCnt   <= '0;
        r_aStride    <= i_a_stride;
        r_romAAddr   <= i_a_base;
        r_romBAddr   <= i_b_base;
        r_cycleCount <= '0;
      end else if (w_busyState && !i_abort) begin
        if (r_cycleCount != 16'hFFFF) r_cycleCount <= r_cycleCount + 16'd1;
        if ((r_state == ISSUE) && !w_lastBeat) begin
          r_beatIdx  <= r_beatIdx + 12'd1;
          r_romAAddr <= r_romAAddr + r_aStride;
          r_romBAddr <= r_romBAddr + 6'd1;
        end
        if (r_state == DRAIN) r_drainCnt <= r_drainCnt + 4'd1;
      end
    end
  end

  assign o_romA_addr         = r_romAAddr;
  assign o_romB_addr         = r_romBAddr;
  assign o_acc_en            = r_issuePipe[ROM_LAT-1];
  assign o_acc_clear         = r_firstPipe[ROM_LAT-1];
  assign o_busy              = r_busy;
  assign o_done              = r_done;
  assign o_result_valid      = r_resultValid;
  assign o_clock_cycle_count = r_cycleCount;

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: default-parameter instance plus a
// single-beat instance for the minimum-length job.
module tb_mac_sequencer;

  localparam int NB     = 64;
  localparam int JOBLEN = 66;

  logic        clock = 1'b0;
  logic        reset_l = 1'b0;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] aBase = '0;
  logic [11:0] aStride = '0;
  logic [5:0]  bBase = '0;

  logic [11:0] romA, romA1;
  logic [5:0]  romB, romB1;
  logic        accEn, accClear, busy, done, resultValid;
  logic        accEn1, accClear1, busy1, done1, resultValid1;
  logic [15:0] cycleCount, cycleCount1;

  int errorCount = 0;
  int checkCount = 0;
  int busyIdx = 0;

  logic [11:0] qRomA[$];
  logic [5:0]  qRomB[$];
  logic        qClear[$];
  logic [15:0] qCount[$];

  always #5 clock = ~clock;

  mac_sequencer dut (
    .i_clock(clock), .i_reset_l(reset_l), .i_start(start), .i_abort(abort),
    .i_a_base(aBase), .i_a_stride(aStride), .i_b_base(bBase),
    .o_romA_addr(romA), .o_romB_addr(romB), .o_acc_en(accEn), .o_acc_clear(accClear),
    .o_busy(busy), .o_done(done), .o_result_valid(resultValid),
    .o_clock_cycle_count(cycleCount)
  );

  mac_sequencer #(.NUM_BEATS(1), .ROM_LAT(1), .TREE_LAT(0)) dut1 (
    .i_clock(clock), .i_reset_l(reset_l), .i_start(start1), .i_abort(abort),
    .i_a_base(aBase), .i_a_stride(aStride), .i_b_base(bBase),
    .o_romA_addr(romA1), .o_romB_addr(romB1), .o_acc_en(accEn1), .o_acc_clear(accClear1),
    .o_busy(busy1), .o_done(done1), .o_result_valid(resultValid1),
    .o_clock_cycle_count(cycleCount1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  task automatic pushJob(input logic [11:0] base, input logic [11:0] stride, input logic [5:0] bb,
                         input bit withCount);
    for (int i = 0; i < NB; i++) begin
      qRomA.push_back(12'(int'(base) + i * int'(stride)));
      qRomB.push_back(6'(int'(bb) + i));
      qClear.push_back(i == 0);
    end
    if (withCount) qCount.push_back(16'(JOBLEN));
  endtask

  task automatic flushQueues();
    qRomA.delete();
    qRomB.delete();
    qClear.delete();
    qCount.delete();
  endtask

  task automatic applyStimulus(input logic [11:0] base, input logic [11:0] stride, input logic [5:0] bb);
    @(posedge clock);
    #1;
    aBase = base;
    aStride = stride;
    bBase = bb;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic waitResult(input int maxCycles);
    bit seen = 0;
    for (int c = 0; c < maxCycles; c++) begin
      @(negedge clock);
      if (resultValid) begin
        seen = 1;
        break;
      end
    end
    checkOutput("jobFinished", seen, 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_romA"}, romA, 0);
    checkOutput({tag, "_romB"}, romB, 0);
    checkOutput({tag, "_accEn"}, accEn, 0);
    checkOutput({tag, "_accClear"}, accClear, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_rv"}, resultValid, 0);
    checkOutput({tag, "_count"}, cycleCount, 0);
  endtask

  // Scoreboard: the first NB busy cycles of a job are its ISSUE beats.
  always @(negedge clock) begin
    if (reset_l) begin
      if (busy) begin
        if (busyIdx < NB) begin
          checkOutput("romA_pending", qRomA.size() != 0, 1);
          if (qRomA.size() != 0) begin
            checkOutput("romA", romA, qRomA.pop_front());
            checkOutput("romB", romB, qRomB.pop_front());
          end
        end
        busyIdx++;
      end else begin
        busyIdx = 0;
      end
      if (accEn) begin
        checkOutput("accEn_pending", qClear.size() != 0, 1);
        if (qClear.size() != 0) checkOutput("accClear", accClear, qClear.pop_front());
      end
      if (resultValid) begin
        checkOutput("result_pending", qCount.size() != 0, 1);
        if (qCount.size() != 0) checkOutput("count", cycleCount, qCount.pop_front());
        checkOutput("doneWithRv", done, 1);
      end
    end else begin
      busyIdx = 0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #2;
    checkAllZero("reset");
    checkOutput("reset_busy1", busy1, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_l = 1'b1;

    // Plain job at defaults.
    pushJob(12'd0, 12'd64, 6'd0, 1);
    applyStimulus(12'd0, 12'd64, 6'd0);
    waitResult(200);
    checkOutput("jobA_busy", busy, 0);
    @(negedge clock);
    checkOutput("jobA_rvPulse", resultValid, 0);
    checkOutput("jobA_doneHold", done, 1);
    checkOutput("jobA_romAHold", romA, 12'hFC0);
    checkOutput("jobA_romBHold", romB, 6'd63);
    checkOutput("jobA_countFrozen", cycleCount, JOBLEN);

    // Address wrap on both ROMs.
    pushJob(12'hFC0, 12'd64, 6'd60, 1);
    applyStimulus(12'hFC0, 12'd64, 6'd60);
    waitResult(200);

    // Start held high: exactly one job, then a restart right after DONE.
    pushJob(12'd100, 12'd3, 6'd5, 1);
    pushJob(12'd100, 12'd3, 6'd5, 1);
    @(posedge clock);
    #1;
    aBase = 12'd100;
    aStride = 12'd3;
    bBase = 6'd5;
    start = 1'b1;
    waitResult(200);
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    checkOutput("held_restartBusy", busy, 1);
    checkOutput("held_restartDone", done, 0);
    waitResult(200);
    repeat (3) @(negedge clock);
    checkOutput("held_noThirdJob", busy, 0);

    // Abort at beat 10.
    pushJob(12'd7, 12'd5, 6'd9, 0);
    applyStimulus(12'd7, 12'd5, 6'd9);
    repeat (10) @(posedge clock);
    #1;
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    @(negedge clock);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_accEn", accEn, 0);
    checkOutput("abort_accClear", accClear, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_count", cycleCount, 10);
    checkOutput("abort_romAHold", romA, 12'd57);
    flushQueues();
    repeat (6) @(negedge clock);
    checkOutput("abort_countFrozen", cycleCount, 10);
    checkOutput("abort_stillIdle", done, 0);

    // Asynchronous reset at beat 30, then a fresh job.
    pushJob(12'd0, 12'd64, 6'd0, 0);
    applyStimulus(12'd0, 12'd64, 6'd0);
    repeat (30) @(posedge clock);
    #1;
    reset_l = 1'b0;
    #1;
    checkAllZero("midReset");
    flushQueues();
    @(posedge clock);
    #1;
    reset_l = 1'b1;
    pushJob(12'd1, 12'd1, 6'd2, 1);
    applyStimulus(12'd1, 12'd1, 6'd2);
    waitResult(200);

    // Single-beat instance.
    @(posedge clock);
    #1;
    start1 = 1'b1;
    @(posedge clock);
    #1;
    start1 = 1'b0;
    @(negedge clock);
    checkOutput("nb1_issueBusy", busy1, 1);
    checkOutput("nb1_issueAccEn", accEn1, 0);
    @(negedge clock);
    checkOutput("nb1_drainBusy", busy1, 1);
    checkOutput("nb1_accEn", accEn1, 1);
    checkOutput("nb1_accClear", accClear1, 1);
    @(negedge clock);
    checkOutput("nb1_done", done1, 1);
    checkOutput("nb1_rv", resultValid1, 1);
    checkOutput("nb1_count", cycleCount1, 2);
    checkOutput("nb1_accEnOff", accEn1, 0);
    checkOutput("nb1_busyOff", busy1, 0);

    repeat (2) @(negedge clock);
    checkOutput("left_romA", qRomA.size(), 0);
    checkOutput("left_clear", qClear.size(), 0);
    checkOutput("left_count", qCount.size(), 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter NUM_BEATS, default 64: dot-product beats issued per job (range 1..4095).
REQ-002 Parameter ROM_LAT, default 1: cycles from ROM address to ROM data (range 1..4).
REQ-003 Parameter TREE_LAT, default 1: cycles from ROM data to accumulator result settled (range 0..4).
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset_l  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  job request; sampled every cycle.
REQ-007 abort  in  1  cancel running job.
REQ-008 a_base  in  12  romA start address.
REQ-009 a_stride  in  12  romA address increment per beat.
REQ-010 b_base  in  6  romB start address.
REQ-011 romA_addr  out  12  registered romA address.
REQ-012 romB_addr  out  6  registered romB address.
REQ-013 acc_en  out  1  accumulator load/add enable, aligned to ROM data.
REQ-014 acc_clear  out  1  accumulator loads instead of adds; asserted only with the first acc_en of a job.
REQ-015 busy  out  1  high in ISSUE and DRAIN.
REQ-016 done  out  1  high in DONE; level.
REQ-017 result_valid  out  1  one-cycle pulse on entry to DONE; display register capture strobe.
REQ-018 clock_cycle_count  out  16  cycles spent busy in current/last job.

Function
REQ-019 FSM states IDLE, ISSUE, DRAIN, DONE; all outputs registered.
REQ-020 IDLE or DONE, start=1: next state ISSUE; beat index i, cycle count cleared to 0; a_base/a_stride/b_base captured.
REQ-021 Start in ISSUE or DRAIN: ignored, no effect on addresses, count or state.
REQ-022 ISSUE cycle i (0..NUM_BEATS-1): romA_addr = a_base + i*a_stride mod 2^12; romB_addr = b_base + i mod 2^6; wrap silently.
REQ-023 ISSUE exits to DRAIN after exactly NUM_BEATS cycles.
REQ-024 Issue-valid delayed ROM_LAT cycles through a shift register drives acc_en; exactly NUM_BEATS acc_en cycles per completed job.
REQ-025 acc_clear high only in the cycle of the first acc_en of a job.
REQ-026 DRAIN lasts exactly ROM_LAT+TREE_LAT cycles, then DONE.
REQ-027 DONE entry: done=1, result_valid=1 for one cycle; done holds until next accepted start.
REQ-028 clock_cycle_count increments each cycle busy=1; saturates at 16'hFFFF; frozen in DONE and IDLE.
REQ-029 Completed-job count = NUM_BEATS+ROM_LAT+TREE_LAT (66 at defaults).
REQ-030 abort=1 in ISSUE or DRAIN: next state IDLE, acc_en shift register flushed, acc_en/acc_clear low next cycle, no result_valid, done stays 0; count frozen.
REQ-031 abort and start same cycle: abort wins; start ignored that cycle.
REQ-032 abort in IDLE or DONE: no effect.
REQ-033 romA_addr/romB_addr hold last value outside ISSUE.

Reset
REQ-034 reset_l=0: state IDLE, romA_addr=0, romB_addr=0, acc_en=0, acc_clear=0, busy=0, done=0, result_valid=0, clock_cycle_count=0, shift register cleared, immediately and without clock.
REQ-035 Reset mid-job discards job; first start after release begins fresh job.

Verification
REQ-036 Defaults, a_base=0, a_stride=64, b_base=0, start pulse -> romA_addr 0,64,...,4032; romB_addr 0..63; acc_en 64 cycles with acc_clear on first; result_valid once; done=1; count=66.
REQ-037 a_base=12'hFC0, a_stride=64, b_base=60 -> romA_addr wraps 12'hFC0 then 0; romB_addr 60..63,0..59.
REQ-038 start held high through entire job -> exactly one job; second job begins cycle after DONE entry.
REQ-039 abort at ISSUE beat 10 -> IDLE next cycle; acc_en low from then on; done=0; no result_valid; count=10.
REQ-040 reset_l low at beat 30 -> all outputs zero asynchronously; new start after release -> full job, count=66.
REQ-041 NUM_BEATS=1, ROM_LAT=1, TREE_LAT=0 -> single acc_en with acc_clear; done after 2 busy cycles; count=2.
